// File: rtl/fifo_uart_tx_if.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_if
// Read-side bus of the team's 16x8 byte FIFO as seen by a consumer.
//
// Signals:
//   fifo_empty         FIFO empty flag (FIFO -> consumer)
//   fifo_dout[7:0]     FIFO read data, valid the cycle after a successful pop
//   fifo_write_enable  monitor copy of the FIFO write strobe (FIFO -> consumer)
//   fifo_read_enable   pop request (consumer -> FIFO)
//
// Handshake: a pop succeeds on a rising clk edge where fifo_read_enable=1,
// fifo_empty=0 and fifo_write_enable=0 (write has priority and the FIFO drops
// the read). fifo_dout holds the popped byte during the following cycle.
//
// Modports:
//   master  the FIFO side (drives flags and data)
//   slave   the consumer side (drives the pop request)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface fifo_uart_tx_if;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_write_enable;
    logic       fifo_read_enable;

    modport master (
        output fifo_empty,
        output fifo_dout,
        output fifo_write_enable,
        input  fifo_read_enable
    );

    modport slave (
        input  fifo_empty,
        input  fifo_dout,
        input  fifo_write_enable,
        output fifo_read_enable
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Pops bytes from the team's 16x8 FIFO and sends each one as an 8N1 UART
// frame, LSB first. Back-to-back frames are separated by only the two
// tx-high cycles needed to pop and capture the next byte.
//
// Optional feature: define FIFO_UART_TX_PARITY_EN to insert an even-parity
// bit between the data bits and the stop bit (8E1, 11 bit periods).
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (2..65535)
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      synchronous active-low reset
//   fifo       FIFO read-side bus (slave modport)
//   tx         serial line, idle high (registered)
//   busy       high whenever the FSM is not IDLE
//   tx_done    one-cycle pulse in the cycle after the stop bit ends (registered)
//   state_dbg  current FSM state encoding, for observation
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic            clk,
    input  logic            reset,
    fifo_uart_tx_if.slave   fifo,
    output logic            tx,
    output logic            busy,
    output logic            tx_done,
    output logic [2:0]      state_dbg
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // Fixed encodings so the debug view is stable with or without parity.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        STOP   = 3'd5
`ifdef FIFO_UART_TX_PARITY_EN
        ,
        PARITY = 3'd6
`endif
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_n;
    logic [2:0]       bit_idx_q, bit_idx_n;
    logic [7:0]       shift_q, shift_n;
    logic             tx_q, tx_n;
    logic             tx_done_q, tx_done_n;
`ifdef FIFO_UART_TX_PARITY_EN
    logic             parity_q, parity_n;
`endif

    logic bit_end;
    assign bit_end = (clk_cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            tx_done_q <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_n;
            clk_cnt_q <= clk_cnt_n;
            bit_idx_q <= bit_idx_n;
            shift_q   <= shift_n;
            tx_q      <= tx_n;
            tx_done_q <= tx_done_n;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q  <= parity_n;
`endif
        end
    end

    // tx_n is the line level for the state being entered, so the registered
    // tx changes on the same edge as the state.
    always_comb begin
        state_n   = state_q;
        clk_cnt_n = clk_cnt_q;
        bit_idx_n = bit_idx_q;
        shift_n   = shift_q;
        tx_n      = tx_q;
        tx_done_n = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_n  = parity_q;
`endif

        unique case (state_q)
            IDLE: begin
                tx_n = 1'b1;
                if (!fifo.fifo_empty) begin
                    state_n = POP;
                end
            end

            POP: begin
                // A concurrent write makes the FIFO ignore this read: retry.
                if (!fifo.fifo_write_enable) begin
                    state_n = LOAD;
                end
            end

            LOAD: begin
                shift_n   = fifo.fifo_dout;
                clk_cnt_n = '0;
                bit_idx_n = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_n  = ^fifo.fifo_dout;
`endif
                tx_n      = 1'b0;
                state_n   = START;
            end

            START: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    bit_idx_n = '0;
                    tx_n      = shift_q[0];
                    state_n   = DATA;
                end else begin
                    clk_cnt_n = clk_cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    shift_n   = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        tx_n    = parity_q;
                        state_n = PARITY;
`else
                        tx_n    = 1'b1;
                        state_n = STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx_q + 3'd1;
                        tx_n      = shift_q[1];
                    end
                end else begin
                    clk_cnt_n = clk_cnt_q + CNT_W'(1);
                end
            end

`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    tx_n      = 1'b1;
                    state_n   = STOP;
                end else begin
                    clk_cnt_n = clk_cnt_q + CNT_W'(1);
                end
            end
`endif

            STOP: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    tx_n      = 1'b1;
                    tx_done_n = 1'b1;
                    // Chain straight into the next pop when more data waits.
                    state_n   = fifo.fifo_empty ? IDLE : POP;
                end else begin
                    clk_cnt_n = clk_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                tx_n    = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    assign fifo.fifo_read_enable = (state_q == POP);
    assign busy                  = (state_q != IDLE);
    assign tx                    = tx_q;
    assign tx_done               = tx_done_q;
    assign state_dbg             = state_q;

endmodule
